// File: rtl/fp_mul_round_pack_if.sv
// Status classification shared with the upstream multiplier, and the
// valid/ready bundle between upstream, this stage and writeback.
package float_type;
    typedef enum logic [2:0] {
        VALID,
        NaN,
        positive_infinity,
        negative_infinity,
        OVERFLOW,
        UNDERFLOW
    } type_of_float;
endpackage

interface fp_mul_round_pack_if;
    import float_type::*;

    logic         in_valid;
    logic         in_ready;
    logic [47:0]  prod;
    logic [9:0]   exp_in;
    logic         sign_in;
    type_of_float status;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  result;
    logic         flag_overflow;
    logic         flag_underflow;
    logic         flag_inexact;
    logic         flag_invalid;

    modport master (
        output in_valid, prod, exp_in, sign_in, status, out_ready,
        input  in_ready, out_valid, result,
               flag_overflow, flag_underflow, flag_inexact, flag_invalid
    );

    modport slave (
        input  in_valid, prod, exp_in, sign_in, status, out_ready,
        output in_ready, out_valid, result,
               flag_overflow, flag_underflow, flag_inexact, flag_invalid
    );
endinterface

// File: rtl/fp_mul_round_pack.sv
// Normalize / round-to-nearest-even / pack stage for a binary32 multiplier.
// Special operands skip normalization but still pass through ROUND for timing.
module fp_mul_round_pack (
    input  logic               clk,
    input  logic               rst,
    fp_mul_round_pack_if.slave bus
);
    import float_type::*;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t             state_q, state_d;
    logic [47:0]        prod_q, prod_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               byp_q, byp_d;
    logic [31:0]        res_q, res_d;
    // {overflow, underflow, inexact, invalid}
    logic [3:0]         flg_q, flg_d;

    logic [23:0]        mant;
    logic               guard, sticky, rnd_up;
    logic [24:0]        mant_sum;
    logic signed [9:0]  exp_r;
    logic [22:0]        frac_r;
    logic [31:0]        pk_res;
    logic [3:0]         pk_flg;
    logic               unused_hidden;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prod_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            byp_q   <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            byp_q   <= byp_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    // Round and pack from the normalized registers.
    always_comb begin
        mant     = prod_q[46:23];
        guard    = prod_q[22];
        sticky   = |prod_q[21:0];
        rnd_up   = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {24'h0, rnd_up};
        exp_r    = mant_sum[24] ? exp_q + 10'sd1 : exp_q;
        frac_r   = mant_sum[24] ? 23'h0 : mant_sum[22:0];
        pk_res   = {sign_q, exp_r[7:0], frac_r};
        pk_flg   = {2'b00, guard | sticky, 1'b0};
        if (exp_r >= 10'sd255) begin
            pk_res = {sign_q, 8'hFF, 23'h0};
            pk_flg = 4'b1010;
        end else if (exp_r <= 10'sd0) begin
            pk_res = {sign_q, 31'h0};
            pk_flg = 4'b0110;
        end
    end

    // Hidden bit is implied by the packed format and never stored.
    assign unused_hidden = mant_sum[23];

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        byp_d   = byp_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    prod_d  = bus.prod;
                    exp_d   = bus.exp_in;
                    sign_d  = bus.sign_in;
                    byp_d   = 1'b1;
                    flg_d   = '0;
                    state_d = ROUND;
                    case (bus.status)
                        NaN: begin
                            res_d = 32'h7FC00000;
                            flg_d = 4'b0001;
                        end
                        positive_infinity, negative_infinity:
                            res_d = {bus.sign_in, 8'hFF, 23'h0};
                        OVERFLOW: begin
                            res_d = {bus.sign_in, 8'hFF, 23'h0};
                            flg_d = 4'b1010;
                        end
                        UNDERFLOW: begin
                            res_d = {bus.sign_in, 31'h0};
                            flg_d = 4'b0110;
                        end
                        default: begin
                            if (bus.prod == 48'h0) begin
                                res_d = {bus.sign_in, 31'h0};
                            end else begin
                                byp_d   = 1'b0;
                                state_d = NORM;
                            end
                        end
                    endcase
                end
            end
            NORM: begin
                // Exponent exhaustion wins: ROUND will flush the result.
                if (exp_q <= 10'sd0) begin
                    state_d = ROUND;
                end else if (prod_q[47]) begin
                    prod_d  = {1'b0, prod_q[47:2], prod_q[1] | prod_q[0]};
                    exp_d   = exp_q + 10'sd1;
                    state_d = ROUND;
                end else if (prod_q[46]) begin
                    state_d = ROUND;
                end else begin
                    prod_d = {prod_q[46:0], 1'b0};
                    exp_d  = exp_q - 10'sd1;
                end
            end
            ROUND: begin
                if (!byp_q) begin
                    res_d = pk_res;
                    flg_d = pk_flg;
                end
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = (state_q == OUT);
    assign bus.result         = res_q;
    assign bus.flag_overflow  = flg_q[3];
    assign bus.flag_underflow = flg_q[2];
    assign bus.flag_inexact   = flg_q[1];
    assign bus.flag_invalid   = flg_q[0];
endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Directed bench for fp_mul_round_pack: vector table plus backpressure and
// mid-operation reset sequences.
module tb_fp_mul_round_pack;
    import float_type::*;

    typedef struct {
        logic [47:0]  prod;
        logic [9:0]   exp;
        logic         sign;
        type_of_float st;
        logic [31:0]  res;
        logic [3:0]   flg;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    vec_t vt[$];

    fp_mul_round_pack_if bus ();

    fp_mul_round_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [47:0] p, input logic [9:0] e, input logic s,
                       input type_of_float st, input logic [31:0] r,
                       input logic [3:0] f, input int l);
        vec_t v;
        v.prod = p; v.exp = e; v.sign = s; v.st = st;
        v.res = r; v.flg = f; v.lat = l;
        vt.push_back(v);
    endtask

    function automatic logic [3:0] flags();
        return {bus.flag_overflow, bus.flag_underflow, bus.flag_inexact, bus.flag_invalid};
    endfunction

    task automatic drive(input logic [47:0] p, input logic [9:0] e, input logic s,
                         input type_of_float st);
        bus.prod = p; bus.exp_in = e; bus.sign_in = s; bus.status = st;
        bus.in_valid = 1'b1;
    endtask

    // Waits for out_valid after an accepting edge; returns edges counted.
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, bus.in_ready, 1);
        drive(v.prod, v.exp, v.sign, v.st);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_out(lat);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " result"}, bus.result, v.res);
        chk({tag, " flags"}, flags(), v.flg);
        @(posedge clk);
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t v;

        bus.in_valid = 1'b0; bus.prod = '0; bus.exp_in = '0; bus.sign_in = 1'b0;
        bus.status = VALID; bus.out_ready = 1'b1;

        //   prod                exp      s     status             result        flags  lat
        add(48'h900000000000, 10'd127, 1'b0, VALID,             32'h40100000, 4'h0, 2);
        add(48'h400000C00000, 10'd127, 1'b0, VALID,             32'h3F800002, 4'h2, 2);
        add(48'h400000400000, 10'd127, 1'b0, VALID,             32'h3F800000, 4'h2, 2);
        add(48'h400000400001, 10'd127, 1'b0, VALID,             32'h3F800001, 4'h2, 2);
        add(48'h7FFFFFC00000, 10'd127, 1'b0, VALID,             32'h40000000, 4'h2, 2);
        add(48'h800000800001, 10'd127, 1'b0, VALID,             32'h40000001, 4'h2, 2);
        add(48'h800000000000, 10'd254, 1'b1, VALID,             32'hFF800000, 4'hA, 2);
        add(48'h400000000000, 10'd255, 1'b0, VALID,             32'h7F800000, 4'hA, 2);
        add(48'h123456789ABC, 10'd127, 1'b0, NaN,               32'h7FC00000, 4'h1, 1);
        add(48'h400000000000, 10'd127, 1'b0, positive_infinity, 32'h7F800000, 4'h0, 1);
        add(48'h400000000000, 10'd127, 1'b1, negative_infinity, 32'hFF800000, 4'h0, 1);
        add(48'h400000000000, 10'd300, 1'b1, OVERFLOW,          32'hFF800000, 4'hA, 1);
        add(48'h400000000000, 10'd1,   1'b0, UNDERFLOW,         32'h00000000, 4'h6, 1);
        add(48'h000000000000, 10'd127, 1'b1, VALID,             32'h80000000, 4'h0, 1);
        add(48'h100000000000, 10'd10,  1'b0, VALID,             32'h04000000, 4'h0, 4);
        add(48'h100000000000, 10'd1,   1'b0, VALID,             32'h00000000, 4'h6, 3);
        add(48'h400000000000, 10'h3FB, 1'b0, VALID,             32'h00000000, 4'h6, 2);
        add(48'h000000000001, 10'd100, 1'b0, VALID,             32'h1B000000, 4'h0, 48);

        repeat (2) @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset result", bus.result, 0);
        chk("reset flags", flags(), 0);
        rst = 1'b0;

        foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

        // Backpressure: result held while the consumer stalls, second beat waits.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(48'h900000000000, 10'd127, 1'b0, VALID);
        @(posedge clk);
        #1 drive(48'h400000000000, 10'd127, 1'b0, VALID);
        wait_out(lat);
        chk("bp first latency", lat, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp hold result c%0d", c), bus.result, 32'h40100000);
            chk($sformatf("bp hold valid c%0d", c), bus.out_valid, 1);
            chk($sformatf("bp in_ready low c%0d", c), bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp after handshake valid", bus.out_valid, 0);
        chk("bp after handshake in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_out(lat);
        chk("bp second latency", lat, 2);
        chk("bp second result", bus.result, 32'h3F800000);
        chk("bp second flags", flags(), 0);
        @(posedge clk);

        // Reset during a long normalization discards the beat.
        @(negedge clk);
        drive(48'h000000000001, 10'd100, 1'b0, VALID);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst result", bus.result, 0);
        chk("rst flags", flags(), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rst discarded beat", seen, 0);
        v = vt[0];
        run_vec(v, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fp_mul_round_pack.md
# fp_mul_round_pack

Sequential normalize/round/pack stage downstream of `product`. It consumes the raw 48-bit mantissa product, biased exponent, sign and `type_of_float` status. It produces a packed IEEE-754 single-precision result with exception flags. Rounding is round-to-nearest-even, and subnormal results flush to zero. Transfers use valid/ready on both sides, so the stage tolerates backpressure from the writeback stage.

## Interface
- No parameters. Formats are fixed at IEEE-754 binary32. The input product is 48 bits with the binary point between bits 46 and 45.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — input beat valid.
- `in_ready` out 1 — stage can accept a beat.
- `prod` in 48 — unsigned mantissa product; value = prod × 2^-46.
- `exp_in` in 10 — signed two's-complement biased exponent, a_exp+b_exp-127, with no wrap.
- `sign_in` in 1 — product sign.
- `status` in `type_of_float` (package `float_type`) — classification from upstream.
- `out_valid` out 1 — result valid.
- `out_ready` in 1 — consumer accepts the result.
- `result` out 32 — packed binary32 result.
- `flag_overflow`, `flag_underflow`, `flag_inexact`, `flag_invalid` out 1 each — exception flags, qualified by `out_valid`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - NORM: normalization loop.
  - ROUND: round and pack.
  - OUT: hold result.
- Accept occurs on `in_valid`&&`in_ready`. The stage registers `prod`, `exp_in`, `sign_in` and `status`.
- Bypass from IDLE→OUT at accept:
  - NaN → 0x7FC00000 with invalid=1.
  - positive_infinity/negative_infinity → {sign_in,8'hFF,23'h0}.
  - OVERFLOW → {sign_in,8'hFF,0} with overflow=1 and inexact=1.
  - UNDERFLOW → {sign_in,31'h0} with underflow=1 and inexact=1.
  - `prod`==0 with any other status → {sign_in,31'h0}, no flags.
- NORM, one action per cycle:
  - If prod[47]=1: prod>>=1 with the shifted-out bit ORed into bit 0 (sticky), exp+=1, then go to ROUND.
  - Else if prod[46]=1: go to ROUND.
  - Else: prod<<=1, exp-=1, stay in NORM.
  - If exp≤0 at any NORM cycle: go to ROUND, which then flushes the result.
- ROUND:
  - Fields: mant=prod[46:23], guard=prod[22], sticky=|prod[21:0].
  - Round up iff guard && (sticky || mant[0]).
  - If the 25-bit mant+1 carries out: mant=0x800000, exp+=1.
  - inexact = guard||sticky.
- Pack:
  - exp≥255 → {sign,8'hFF,0}, overflow=1, inexact=1.
  - exp≤0 → {sign,31'h0}, underflow=1, inexact=1.
  - Otherwise → {sign,exp[7:0],mant[22:0]}.
- OUT: `out_valid`=1. Go to IDLE on `out_ready`.

## Timing
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0; `result`=0; all flags 0. Internal registers are cleared.
- Reset asserted mid-operation discards the beat in flight. No output is produced for it.
- Latency, counted from the accepting edge to the edge where `out_valid` rises:
  - Normal path: 2 cycles + n, where n = number of left shifts.
  - Bypass path: 1 cycle.
- Worst case is 48 cycles.
- `in_ready`=1 only in IDLE. There is no same-cycle pass-through, so throughput is at most one beat per latency+1 cycles.
- While `out_valid`&&!`out_ready`, `result` and the flags are held stable.
- OUT→IDLE on the handshake edge. `in_ready` rises in the following cycle.
- `in_valid` while `in_ready`=0 is ignored. Upstream holds its beat.

## Test plan
- 1.5×1.5: prod=0x900000000000, exp_in=127, sign 0, status VALID → result 0x40100000, no flags, `out_valid` 2 cycles after accept.
- Rounding:
  - prod=0x400000C00000, exp_in=127 (tie, odd lsb) → 0x3F800002, inexact=1.
  - prod=0x400000400000 (tie, even lsb) → 0x3F800000, inexact=1.
  - prod=0x7FFFFFC00000 (mantissa carry-out) → 0x40000000, inexact=1.
- Overflow:
  - prod=0x800000000000, exp_in=254, sign 1 → 0xFF800000 with overflow=1.
  - status NaN → 0x7FC00000 with invalid=1, 1-cycle latency.
  - status UNDERFLOW, sign 0 → 0x00000000 with underflow=1.
- Denormal input:
  - prod=0x100000000000, exp_in=10 → two left shifts, result 0x04000000, latency 4.
  - Same prod with exp_in=1 → flush to 0x00000000 with underflow=1.
- Backpressure: hold `out_ready`=0 for 3 cycles → result stable, `in_ready`=0, second beat stalled. Release → second beat accepted one cycle after the handshake.
- Assert `rst` during NORM → all outputs return to reset values immediately. The next beat completes normally.
